spi_cmd_parser: RTL and testbench

- Byte-level command decoder between the SPI byte front-end and the raster memory block.
- Consumes de-serialized MCU bytes framed by chip-select and decodes opcode plus payload.
- Drives the raster memory packet interface: opcode/header/per-item valid strobes with assembled vertex, triangle and transform words.
- Runs on one clock. Bytes arrive as single-cycle `rx_valid` pulses.

---
 rtl/spi_cmd_parser.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_cmd_parser.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: decodes framed SPI command bytes into raster memory packets.
// Define PARSER_TIMEOUT_EN to abort a packet after TIMEOUT_CYC idle cycles.
module spi_cmd_parser #(
   parameter int VTX_W       = 108,
   parameter int VIDX_W      = 8,
   parameter int TRI_W       = 24,
   parameter int TRANS_W     = 288,
   parameter int BASE_W      = 13,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_active,
   input  logic               rx_valid,
   input  logic [7:0]         rx_byte,
   output logic               opcode_valid,
   output logic [3:0]         opcode,
   output logic               vert_valid,
   output logic [BASE_W-1:0]  vert_base,
   output logic [VIDX_W-1:0]  vert_count,
   output logic               next_vert_valid,
   output logic [VTX_W-1:0]   vert_in,
   output logic               tri_valid,
   output logic [BASE_W-1:0]  tri_base,
   output logic [VIDX_W-1:0]  tri_count,
   output logic               next_tri_valid,
   output logic [TRI_W-1:0]   tri_in,
   output logic               inst_valid,
   output logic [VIDX_W-1:0]  vert_id_in,
   output logic [VIDX_W-1:0]  tri_id_in,
   output logic [7:0]         inst_id_in,
   output logic [TRANS_W-1:0] transform_in,
   output logic               busy,
   output logic               err_abort
);

   typedef enum logic [2:0] {
      IDLE, HDR, VERT_DATA, TRI_DATA, INST_DATA
   } state_t;

   state_t state, state_n;
   logic acc, tmo;
   logic [TRANS_W-1:0] sreg, sreg_n;
   logic [5:0] byte_cnt, byte_cnt_n, inst_last;
   logic [7:0] item_cnt, item_cnt_n, cnt_r, cnt_n;
   logic [7:0] id0_r, id0_n, id1_r, id1_n;
   logic [3:0] op_r, op_n;
   logic op_hit, hdr_done, vtx_done, tri_done, inst_done, abort;

   assign acc  = rx_valid & frame_active;
   assign busy = (state != IDLE);
   assign inst_last = (op_r == 4'h3) ? 6'd37 : 6'd36;

`ifdef PARSER_TIMEOUT_EN
   logic [15:0] idle_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idle_cnt <= '0;
      else if (acc || state == IDLE)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 16'd1;
   end

   assign tmo = (idle_cnt == 16'(TIMEOUT_CYC));
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sreg     <= '0;
         byte_cnt <= '0;
         item_cnt <= '0;
         cnt_r    <= '0;
         op_r     <= '0;
         id0_r    <= '0;
         id1_r    <= '0;
      end else begin
         state    <= state_n;
         sreg     <= sreg_n;
         byte_cnt <= byte_cnt_n;
         item_cnt <= item_cnt_n;
         cnt_r    <= cnt_n;
         op_r     <= op_n;
         id0_r    <= id0_n;
         id1_r    <= id1_n;
      end
   end

   always_comb begin
      state_n    = state;
      sreg_n     = sreg;
      byte_cnt_n = byte_cnt;
      item_cnt_n = item_cnt;
      cnt_n      = cnt_r;
      op_n       = op_r;
      id0_n      = id0_r;
      id1_n      = id1_r;
      op_hit     = 1'b0;
      hdr_done   = 1'b0;
      vtx_done   = 1'b0;
      tri_done   = 1'b0;
      inst_done  = 1'b0;
      abort      = 1'b0;
      if (acc)
         sreg_n = {sreg[TRANS_W-9:0], rx_byte};
      // Abort wins over any byte; a byte with frame low is never accepted
      if (state != IDLE && (!frame_active || tmo)) begin
         abort      = 1'b1;
         state_n    = IDLE;
         byte_cnt_n = '0;
         item_cnt_n = '0;
      end else if (acc) begin
         byte_cnt_n = byte_cnt + 6'd1;
         case (state)
            IDLE: begin
               op_hit     = 1'b1;
               op_n       = rx_byte[3:0];
               byte_cnt_n = '0;
               case (rx_byte[3:0])
                  4'h1, 4'h2: state_n = HDR;
                  4'h3, 4'h4: state_n = INST_DATA;
                  default:    state_n = IDLE;
               endcase
            end
            HDR: begin
               if (byte_cnt == 6'd2) begin
                  hdr_done   = 1'b1;
                  byte_cnt_n = '0;
                  item_cnt_n = '0;
                  cnt_n      = rx_byte;
                  if (rx_byte == 8'd0)
                     state_n = IDLE;
                  else if (op_r == 4'h1)
                     state_n = VERT_DATA;
                  else
                     state_n = TRI_DATA;
               end
            end
            VERT_DATA, TRI_DATA: begin
               if ((state == VERT_DATA && byte_cnt == 6'd13) ||
                   (state == TRI_DATA && byte_cnt == 6'd2)) begin
                  vtx_done   = (state == VERT_DATA);
                  tri_done   = (state == TRI_DATA);
                  byte_cnt_n = '0;
                  item_cnt_n = item_cnt + 8'd1;
                  if (item_cnt_n == cnt_r)
                     state_n = IDLE;
               end
            end
            INST_DATA: begin
               // Leading ids are shifted out of sreg by the transform
               if (byte_cnt == 6'd0)
                  id0_n = rx_byte;
               if (byte_cnt == 6'd1)
                  id1_n = rx_byte;
               if (byte_cnt == inst_last) begin
                  inst_done  = 1'b1;
                  byte_cnt_n = '0;
                  state_n    = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode_valid    <= 1'b0;
         opcode          <= '0;
         vert_valid      <= 1'b0;
         vert_base       <= '0;
         vert_count      <= '0;
         next_vert_valid <= 1'b0;
         vert_in         <= '0;
         tri_valid       <= 1'b0;
         tri_base        <= '0;
         tri_count       <= '0;
         next_tri_valid  <= 1'b0;
         tri_in          <= '0;
         inst_valid      <= 1'b0;
         vert_id_in      <= '0;
         tri_id_in       <= '0;
         inst_id_in      <= '0;
         transform_in    <= '0;
         err_abort       <= 1'b0;
      end else begin
         opcode_valid    <= op_hit;
         vert_valid      <= hdr_done && op_r == 4'h1;
         tri_valid       <= hdr_done && op_r == 4'h2;
         next_vert_valid <= vtx_done;
         next_tri_valid  <= tri_done;
         inst_valid      <= inst_done;
         err_abort       <= abort;
         if (op_hit)
            opcode <= rx_byte[3:0];
         if (hdr_done && op_r == 4'h1) begin
            vert_base  <= sreg_n[8 +: BASE_W];
            vert_count <= VIDX_W'(rx_byte);
         end
         if (hdr_done && op_r == 4'h2) begin
            tri_base  <= sreg_n[8 +: BASE_W];
            tri_count <= VIDX_W'(rx_byte);
         end
         if (vtx_done)
            vert_in <= sreg_n[VTX_W-1:0];
         if (tri_done)
            tri_in <= sreg_n[TRI_W-1:0];
         if (inst_done) begin
            transform_in <= sreg_n;
            if (op_r == 4'h3) begin
               vert_id_in <= VIDX_W'(id0_r);
               tri_id_in  <= VIDX_W'(id1_r);
            end else begin
               inst_id_in <= id0_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_cmd_parser.sv
// tb_spi_cmd_parser: directed packets with a scoreboard queue of expected strobes.
// Timeout test runs only when PARSER_TIMEOUT_EN is defined (TIMEOUT_CYC=100).
module tb_spi_cmd_parser;

   localparam int K_OP = 0, K_VH = 1, K_NV = 2, K_TH = 3;
   localparam int K_NT = 4, K_IN = 5, K_AB = 6;

   logic clk = 0, rst = 1, frame_active = 0, rx_valid = 0;
   logic [7:0] rx_byte = 0;
   logic opcode_valid, vert_valid, next_vert_valid, tri_valid;
   logic next_tri_valid, inst_valid, busy, err_abort;
   logic [3:0] opcode;
   logic [12:0] vert_base, tri_base;
   logic [7:0] vert_count, tri_count, vert_id_in, tri_id_in, inst_id_in;
   logic [107:0] vert_in;
   logic [23:0] tri_in;
   logic [287:0] transform_in;

   spi_cmd_parser #(.TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst(rst), .frame_active(frame_active),
      .rx_valid(rx_valid), .rx_byte(rx_byte),
      .opcode_valid(opcode_valid), .opcode(opcode),
      .vert_valid(vert_valid), .vert_base(vert_base),
      .vert_count(vert_count), .next_vert_valid(next_vert_valid),
      .vert_in(vert_in), .tri_valid(tri_valid), .tri_base(tri_base),
      .tri_count(tri_count), .next_tri_valid(next_tri_valid),
      .tri_in(tri_in), .inst_valid(inst_valid),
      .vert_id_in(vert_id_in), .tri_id_in(tri_id_in),
      .inst_id_in(inst_id_in), .transform_in(transform_in),
      .busy(busy), .err_abort(err_abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      logic [319:0] data;
   } ev_t;

   ev_t q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic push(input int kind, input logic [319:0] d);
      ev_t e;
      e.kind = kind;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic got(input int kind, input logic [319:0] d);
      ev_t e;
      vectors++;
      if (q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected strobe kind %0d: got %h, required none",
                  kind, d);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.data !== d) begin
            miscompares++;
            $display("FAIL strobe: got kind %0d data %h, required kind %0d data %h",
                     kind, d, e.kind, e.data);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (opcode_valid)    got(K_OP, 320'(opcode));
         if (vert_valid)      got(K_VH, 320'({vert_base, vert_count}));
         if (next_vert_valid) got(K_NV, 320'(vert_in));
         if (tri_valid)       got(K_TH, 320'({tri_base, tri_count}));
         if (next_tri_valid)  got(K_NT, 320'(tri_in));
         if (inst_valid)
            got(K_IN, 320'({vert_id_in, tri_id_in, inst_id_in, transform_in}));
         if (err_abort)       got(K_AB, 320'd0);
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1;
      rx_byte  = b;
      @(posedge clk); #1;
      rx_valid = 0;
   endtask

   task automatic frame_end();
      @(posedge clk); #1;
      frame_active = 0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] any_out();
      return 32'(|{opcode_valid, opcode, vert_valid, vert_base, vert_count,
                   next_vert_valid, vert_in, tri_valid, tri_base, tri_count,
                   next_tri_valid, tri_in, inst_valid, vert_id_in, tri_id_in,
                   inst_id_in, transform_in, busy, err_abort});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [111:0] v;
      logic [287:0] t1, t2;
      logic [7:0] b;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", any_out(), 0);
      rst = 0;

      // reset in the middle of vertex 0
      frame_active = 1;
      push(K_OP, 1);
      send(8'h01); send(8'h00); send(8'h10);
      push(K_VH, {13'h010, 8'd2});
      send(8'h02);
      for (int i = 0; i < 5; i++) send(8'h40 + 8'(i));
      @(posedge clk); #1;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("midpkt_reset_outs", any_out(), 0);
      chk("midpkt_reset_busy", 32'(busy), 0);
      rst = 0;
      push(K_OP, 0);
      send(8'h00);
      frame_end();

      // two vertices
      frame_active = 1;
      push(K_OP, 1);
      send(8'h01); send(8'h00); send(8'h10);
      push(K_VH, {13'h010, 8'd2});
      send(8'h02);
      for (int k = 0; k < 2; k++) begin
         v = '0;
         for (int j = 0; j < 14; j++) begin
            b = 8'h30 + 8'(14 * k + j);
            v = {v[103:0], b};
         end
         push(K_NV, 320'(v[107:0]));
         for (int j = 0; j < 14; j++) send(8'h30 + 8'(14 * k + j));
      end
      chk("vert_busy_done", 32'(busy), 0);
      frame_end();

      // one triangle, then zero-count header and invalid opcode
      frame_active = 1;
      push(K_OP, 2);
      send(8'h02); send(8'h00); send(8'h20);
      push(K_TH, {13'h020, 8'd1});
      send(8'h01);
      push(K_NT, 24'hAABBCC);
      send(8'hAA); send(8'hBB); send(8'hCC);
      push(K_OP, 2);
      send(8'h02); send(8'h00); send(8'h30);
      push(K_TH, {13'h030, 8'd0});
      send(8'h00);
      chk("zero_cnt_busy", 32'(busy), 0);
      push(K_OP, 5);
      send(8'h05);
      chk("bad_op_busy", 32'(busy), 0);
      frame_end();

      // instance create then update, back-to-back in one frame
      frame_active = 1;
      for (int i = 0; i < 36; i++) begin
         t1 = {t1[279:0], 8'h01 + 8'(i)};
         t2 = {t2[279:0], 8'h80 + 8'(i)};
      end
      push(K_OP, 3);
      send(8'h03); send(8'h05); send(8'h07);
      push(K_IN, {8'd5, 8'd7, 8'd0, t1});
      for (int i = 0; i < 36; i++) send(8'h01 + 8'(i));
      push(K_OP, 4);
      send(8'h04); send(8'h09);
      push(K_IN, {8'd5, 8'd7, 8'd9, t2});
      for (int i = 0; i < 36; i++) send(8'h80 + 8'(i));
      frame_end();

      // frame drop inside vertex data
      frame_active = 1;
      push(K_OP, 1);
      send(8'h01); send(8'h00); send(8'h00);
      push(K_VH, {13'h000, 8'd3});
      send(8'h03);
      for (int i = 0; i < 10; i++) send(8'h60 + 8'(i));
      push(K_AB, 0);
      frame_end();
      chk("abort_busy", 32'(busy), 0);
      frame_active = 1;
      push(K_OP, 7);
      send(8'h07);
      frame_end();

      // completing byte coincides with frame drop
      frame_active = 1;
      push(K_OP, 2);
      send(8'h02); send(8'h00); send(8'h20);
      push(K_TH, {13'h020, 8'd1});
      send(8'h01);
      send(8'hAA); send(8'hBB);
      push(K_AB, 0);
      @(posedge clk); #1;
      rx_valid = 1;
      rx_byte = 8'hCC;
      frame_active = 0;
      @(posedge clk); #1;
      rx_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("gate_abort_busy", 32'(busy), 0);

`ifdef PARSER_TIMEOUT_EN
      frame_active = 1;
      push(K_OP, 2);
      send(8'h02); send(8'h00);
      chk("tmo_busy_before", 32'(busy), 1);
      push(K_AB, 0);
      repeat (120) @(posedge clk);
      #1;
      chk("tmo_busy_after", 32'(busy), 0);
      frame_end();
`endif

      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
